cpx_multiply_pipe: RTL and testbench

Pipelined, back-pressure-aware complex multiplier: accepts one complex pair (xi + j·xq, yi + j·yq) per cycle on a valid/ready input handshake and emits the product (i_out + j·q_out) on a valid/ready output handshake. It is the DUT-side end of the stimulus/response stream the `cpx_multiply` benches drive: it consumes `m_axis_tvalid` plus samples, and produces `s_axis_tvalid` plus results. It sits in the CAF datapath between the reference/received sample sources and the correlation accumulator.

---
 rtl/cpx_pkg.sv | 23 ++
 rtl/cpx_pipe_stage.sv | 30 +++
 rtl/cpx_multiply_pipe.sv | 109 ++++++++++
 tb/tb_cpx_multiply_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpx_pkg.sv
// Shared widths and helpers for the complex multiplier pipeline.
package cpx_pkg;

    localparam int unsigned CPX_X_BITS = 8;
    localparam int unsigned CPX_Y_BITS = 8;

    // Width that holds any sum of two X*Y products without overflow.
    function automatic int unsigned cpx_full_bits(input int unsigned x_bits,
                                                  input int unsigned y_bits);
        return x_bits + y_bits + 1;
    endfunction

    // Right-shift that reduces the full-precision result to the output width.
    function automatic int unsigned cpx_shift_bits(input int unsigned full_bits,
                                                   input int unsigned out_bits);
        return full_bits - out_bits;
    endfunction

    localparam int unsigned CPX_FULL_BITS  = cpx_full_bits(CPX_X_BITS, CPX_Y_BITS);
    localparam int unsigned CPX_OUT_BITS   = CPX_FULL_BITS;
    localparam int unsigned CPX_SHIFT_BITS = cpx_shift_bits(CPX_FULL_BITS, CPX_OUT_BITS);

endpackage

// File: rtl/cpx_pipe_stage.sv
// Valid/ready register slice: loads whenever empty or downstream is taking its data.
module cpx_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         ready_out_c,
    output logic         valid_out,
    output logic [W-1:0] data_out,
    input  logic         ready_in
);

    assign ready_out_c = !valid_out || ready_in;

    // Hold when blocked; data only captured for real samples so outputs stay quiet on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (ready_out_c) begin
            valid_out <= valid_in;
            if (valid_in) begin
                data_out <= data_in;
            end
        end
    end

endmodule

// File: rtl/cpx_multiply_pipe.sv
// Three-stage valid/ready complex multiplier.
// Define CPX_MULTIPLY_CONJ_EN to compute x*conj(y) instead of x*y.
module cpx_multiply_pipe
    import cpx_pkg::*;
#(
    parameter int unsigned X_BITS   = CPX_X_BITS,
    parameter int unsigned Y_BITS   = CPX_Y_BITS,
    parameter int unsigned OUT_BITS = cpx_full_bits(X_BITS, Y_BITS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic signed [X_BITS-1:0]   xi,
    input  logic signed [X_BITS-1:0]   xq,
    input  logic signed [Y_BITS-1:0]   yi,
    input  logic signed [Y_BITS-1:0]   yq,
    output logic                       s_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic signed [OUT_BITS-1:0] i_out,
    output logic signed [OUT_BITS-1:0] q_out
);

    localparam int unsigned P_BITS = X_BITS + Y_BITS;
    localparam int unsigned FULL   = cpx_full_bits(X_BITS, Y_BITS);
    localparam int unsigned SHIFT  = cpx_shift_bits(FULL, OUT_BITS);
    localparam int unsigned W1     = 2 * X_BITS + 2 * Y_BITS;
    localparam int unsigned W2     = 4 * P_BITS;
    localparam int unsigned W3     = 2 * OUT_BITS;

    logic          ready1_c, ready2_c, ready3_c;
    logic          v1, v2, v3;
    logic [W1-1:0] s1_data;
    logic [W2-1:0] s2_data, s2_next;
    logic [W3-1:0] s3_data, s3_next;

    logic signed [X_BITS-1:0] s1_xi, s1_xq;
    logic signed [Y_BITS-1:0] s1_yi, s1_yq;
    logic signed [P_BITS-1:0] p_ii, p_qq, p_iq, p_qi;
    logic signed [P_BITS-1:0] s2_ii, s2_qq, s2_iq, s2_qi;
    logic signed [FULL-1:0]   sum_i, sum_q;
    logic signed [OUT_BITS-1:0] red_i, red_q;

    // S1: registered operands
    cpx_pipe_stage #(.W(W1)) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (m_axis_tvalid),
        .data_in    ({xi, xq, yi, yq}),
        .ready_out_c(ready1_c),
        .valid_out  (v1),
        .data_out   (s1_data),
        .ready_in   (ready2_c)
    );

    assign {s1_xi, s1_xq, s1_yi, s1_yq} = s1_data;

    // Partial products; each fits P_BITS even for all-minimum operands.
    assign p_ii = P_BITS'(s1_xi) * P_BITS'(s1_yi);
    assign p_qq = P_BITS'(s1_xq) * P_BITS'(s1_yq);
    assign p_iq = P_BITS'(s1_xi) * P_BITS'(s1_yq);
    assign p_qi = P_BITS'(s1_xq) * P_BITS'(s1_yi);
    assign s2_next = {p_ii, p_qq, p_iq, p_qi};

    // S2: four products
    cpx_pipe_stage #(.W(W2)) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (v1),
        .data_in    (s2_next),
        .ready_out_c(ready2_c),
        .valid_out  (v2),
        .data_out   (s2_data),
        .ready_in   (ready3_c)
    );

    assign {s2_ii, s2_qq, s2_iq, s2_qi} = s2_data;

`ifdef CPX_MULTIPLY_CONJ_EN
    assign sum_i = FULL'(s2_ii) + FULL'(s2_qq);
    assign sum_q = FULL'(s2_qi) - FULL'(s2_iq);
`else
    assign sum_i = FULL'(s2_ii) - FULL'(s2_qq);
    assign sum_q = FULL'(s2_iq) + FULL'(s2_qi);
`endif

    // Floor-truncate to the output width (arithmetic shift, no rounding).
    assign red_i   = OUT_BITS'(sum_i >>> SHIFT);
    assign red_q   = OUT_BITS'(sum_q >>> SHIFT);
    assign s3_next = {red_i, red_q};

    // S3: reduced result driving the outputs
    cpx_pipe_stage #(.W(W3)) u_s3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (v2),
        .data_in    (s3_next),
        .ready_out_c(ready3_c),
        .valid_out  (v3),
        .data_out   (s3_data),
        .ready_in   (m_axis_tready)
    );

    assign s_axis_tready = ready1_c;
    assign s_axis_tvalid = v3;
    assign i_out         = s3_data[W3-1:OUT_BITS];
    assign q_out         = s3_data[OUT_BITS-1:0];

endmodule

// File: tb/tb_cpx_multiply_pipe.sv
// Directed bench for cpx_multiply_pipe (default 8/8/17 plus an OUT_BITS=8 instance).
// Honors CPX_MULTIPLY_CONJ_EN for the expected values.
module tb_cpx_multiply_pipe;

    logic clk = 1'b0;
    logic rst_n;
    logic m_axis_tvalid, m_axis_tready;
    logic signed [7:0] xi, xq, yi, yq;
    logic s_axis_tvalid, s_axis_tready;
    logic signed [16:0] i_out, q_out;
    logic s_axis_tvalid8, s_axis_tready8;
    logic signed [7:0] i_out8, q_out8;

    int n_assert = 0;
    int n_fail   = 0;

    int tab_xi [8] = '{3, -128, 1, -7, 127,  10,  0, -1};
    int tab_xq [8] = '{4, -128, 2,  5,  -1,   0, -3, -1};
    int tab_yi [8] = '{5, -128, 3,  2,  -1, -10,  0, -1};
    int tab_yq [8] = '{-2, 127, 4, -3, 127,   0, -3, -1};
`ifdef CPX_MULTIPLY_CONJ_EN
    int exp_i [8] = '{7, 128, 11, -29, -254, -100, 9, 2};
    int exp_q [8] = '{26, 32640, 2, -11, -16128, 0, 0, 0};
    int exp8_i = 0;
    int exp8_q = 63;
`else
    int exp_i [8] = '{23, 32640, -5, 1, 0, -100, -9, 0};
    int exp_q [8] = '{14, 128, 10, 31, 16130, 0, 0, 2};
    int exp8_i = 63;
    int exp8_q = 0;
`endif

    always #5 clk = ~clk;

    cpx_multiply_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_axis_tvalid(m_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .xi           (xi),
        .xq           (xq),
        .yi           (yi),
        .yq           (yq),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .i_out        (i_out),
        .q_out        (q_out)
    );

    cpx_multiply_pipe #(.OUT_BITS(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_axis_tvalid(m_axis_tvalid),
        .s_axis_tready(s_axis_tready8),
        .xi           (xi),
        .xq           (xq),
        .yi           (yi),
        .yq           (yq),
        .s_axis_tvalid(s_axis_tvalid8),
        .m_axis_tready(m_axis_tready),
        .i_out        (i_out8),
        .q_out        (q_out8)
    );

    task automatic check(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input int idx);
        xi = 8'(tab_xi[idx]);
        xq = 8'(tab_xq[idx]);
        yi = 8'(tab_yi[idx]);
        yq = 8'(tab_yq[idx]);
    endtask

    task automatic junk();
        xi = 8'($urandom);
        xq = 8'($urandom);
        yi = 8'($urandom);
        yq = 8'($urandom);
    endtask

    // Push count consecutive table entries from a negedge; check cycle-exact output timing.
    task automatic run_stream(input int first, input int count);
        m_axis_tready = 1'b1;
        for (int c = 0; c < count + 3; c++) begin
            if (c < count) begin
                m_axis_tvalid = 1'b1;
                drive(first + c);
            end else begin
                m_axis_tvalid = 1'b0;
                junk();
            end
            @(negedge clk);
            if (c >= 2 && c < count + 2) begin
                check("stream_valid", int'(s_axis_tvalid), 1);
                check("stream_i", int'(i_out), exp_i[first + c - 2]);
                check("stream_q", int'(q_out), exp_q[first + c - 2]);
                if (first + c - 2 == 1) begin
                    check("ext8_valid", int'(s_axis_tvalid8), 1);
                    check("ext8_i", int'(i_out8), exp8_i);
                    check("ext8_q", int'(q_out8), exp8_q);
                end
            end else begin
                check("stream_idle", int'(s_axis_tvalid), 0);
            end
        end
    endtask

    initial begin
        int pushed;
        int popped;
        int held_i;
        int held_q;
        bit was_stalled;

        // Reset with live-looking inputs that must be ignored
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        m_axis_tvalid = 1'b1;
        drive(0);
        repeat (3) @(negedge clk);
        check("rst_valid", int'(s_axis_tvalid), 0);
        check("rst_i", int'(i_out), 0);
        check("rst_q", int'(q_out), 0);
        rst_n = 1'b1;
        m_axis_tvalid = 1'b0;
        #1;
        check("rst_ready", int'(s_axis_tready), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_idle", int'(s_axis_tvalid), 0);
        end

        // Single sample, extremes (both widths), then four back-to-back
        run_stream(0, 1);
        run_stream(1, 1);
        run_stream(2, 4);

        // Backpressure: downstream stalls for 6 cycles while 8 samples stream in
        pushed = 0;
        popped = 0;
        held_i = 0;
        held_q = 0;
        was_stalled = 1'b0;
        for (int c = 0; c < 40 && popped < 8; c++) begin
            m_axis_tready = !(c >= 2 && c <= 7);
            if (pushed < 8) begin
                m_axis_tvalid = 1'b1;
                drive(pushed);
            end else begin
                m_axis_tvalid = 1'b0;
                junk();
            end
            #1;
            if (c == 3) check("bp_accepts_when_full", pushed, 3);
            if (c >= 3 && c <= 7) check("bp_tready_low", int'(s_axis_tready), 0);
            if (s_axis_tvalid && !m_axis_tready) begin
                if (was_stalled) begin
                    check("bp_hold_i", int'(i_out), held_i);
                    check("bp_hold_q", int'(q_out), held_q);
                end
                held_i = int'(i_out);
                held_q = int'(q_out);
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (s_axis_tvalid && m_axis_tready) begin
                check("bp_pop_i", int'(i_out), exp_i[popped]);
                check("bp_pop_q", int'(q_out), exp_q[popped]);
                popped++;
            end
            if (m_axis_tvalid && s_axis_tready) pushed++;
            @(negedge clk);
        end
        check("bp_all_pushed", pushed, 8);
        check("bp_all_popped", popped, 8);
        check("bp_drained", int'(s_axis_tvalid), 0);

        // Reset with two samples in flight: they must vanish
        m_axis_tready = 1'b1;
        m_axis_tvalid = 1'b1;
        drive(6);
        @(negedge clk);
        drive(7);
        @(negedge clk);
        m_axis_tvalid = 1'b0;
        junk();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(s_axis_tvalid), 0);
        check("midrst_i", int'(i_out), 0);
        check("midrst_q", int'(q_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", int'(s_axis_tready), 1);
        @(negedge clk);
        run_stream(2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
